// File: rtl/forward_ctrl_pkg.sv
// forward_ctrl_pkg: shared widths, zero-register constant and shadow-entry type
package forward_ctrl_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W = 5;
  localparam int CNT_W = 16;
  localparam int ZERO_REG = 0;
  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
    logic              is_load;
  } shadow_t;
endpackage

// File: rtl/forward_ctrl_if.sv
// forward_ctrl_if: pipeline-side signals of the forwarding/hazard controller
interface forward_ctrl_if #(
  parameter int DATA_W = forward_ctrl_pkg::DATA_W,
  parameter int REG_W = forward_ctrl_pkg::REG_W,
  parameter int CNT_W = forward_ctrl_pkg::CNT_W
);
  import forward_ctrl_pkg::*;
  logic              ExeValid_IN;
  logic              ExeRegWrite_IN;
  logic              ExeIsLoad_IN;
  logic [REG_W-1:0]  ExeDest_IN;
  logic [REG_W-1:0]  ExeRs_IN;
  logic [REG_W-1:0]  ExeRt_IN;
  logic [DATA_W-1:0] ExeOperandA_IN;
  logic [DATA_W-1:0] ExeOperandB_IN;
  logic              ExeUsesRt_IN;
  logic [DATA_W-1:0] ALUResult_IN;
  logic [DATA_W-1:0] MemData_IN;
  logic [REG_W-1:0]  IdRs_IN;
  logic [REG_W-1:0]  IdRt_IN;
  logic              IdUsesRt_IN;
  logic              Flush_IN;
  logic              forward_OUT;
  logic              Fmem_forward_OUT;
  logic [DATA_W-1:0] FOperandA_OUT;
  logic [DATA_W-1:0] FOperandB_OUT;
  logic [DATA_W-1:0] S_operandA_OUT;
  logic [DATA_W-1:0] S_operandB_OUT;
  logic              Stall_OUT;
  logic              HazardErr_OUT;
  logic [CNT_W-1:0]  StallCount_OUT;
  modport master (
    output ExeValid_IN, ExeRegWrite_IN, ExeIsLoad_IN, ExeDest_IN, ExeRs_IN, ExeRt_IN,
           ExeOperandA_IN, ExeOperandB_IN, ExeUsesRt_IN, ALUResult_IN, MemData_IN,
           IdRs_IN, IdRt_IN, IdUsesRt_IN, Flush_IN,
    input  forward_OUT, Fmem_forward_OUT, FOperandA_OUT, FOperandB_OUT,
           S_operandA_OUT, S_operandB_OUT, Stall_OUT, HazardErr_OUT, StallCount_OUT
  );
  modport slave (
    input  ExeValid_IN, ExeRegWrite_IN, ExeIsLoad_IN, ExeDest_IN, ExeRs_IN, ExeRt_IN,
           ExeOperandA_IN, ExeOperandB_IN, ExeUsesRt_IN, ALUResult_IN, MemData_IN,
           IdRs_IN, IdRt_IN, IdUsesRt_IN, Flush_IN,
    output forward_OUT, Fmem_forward_OUT, FOperandA_OUT, FOperandB_OUT,
           S_operandA_OUT, S_operandB_OUT, Stall_OUT, HazardErr_OUT, StallCount_OUT
  );
endinterface

// File: rtl/forward_ctrl_stage.sv
// fwd_stage_reg: one shadow pipeline entry whose valid bit clears on sync active-low reset
module fwd_stage_reg #(
  parameter type entry_t = forward_ctrl_pkg::shadow_t
) (
  input  logic   CLOCK,
  input  logic   RESET,
  input  entry_t entry_d,
  output entry_t entry_o
);
  import forward_ctrl_pkg::*;
  entry_t entry_q;
  always_ff @(posedge CLOCK) begin
    entry_q <= entry_d;
    if (!RESET) entry_q.valid <= 1'b0;
  end
  assign entry_o = entry_q;
endmodule

// File: rtl/forward_ctrl.sv
// forward_ctrl: EXE operand forwarding from two shadow stages plus load-use stall detection
module forward_ctrl #(
  parameter int DATA_W = forward_ctrl_pkg::DATA_W,
  parameter int REG_W = forward_ctrl_pkg::REG_W,
  parameter int CNT_W = forward_ctrl_pkg::CNT_W
) (
  input logic CLOCK,
  input logic RESET,
  forward_ctrl_if.slave bus
);
  import forward_ctrl_pkg::*;
  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
    logic              is_load;
  } entry_t;
  entry_t s1_d, s1_q, s2_d, s2_q;
  logic exe_wr, stall, m1a, m1b, m2a, m2b, fwd, hazard_d, hazard_q;
  logic [DATA_W-1:0] opa, opb;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  always_comb begin
    exe_wr = bus.ExeValid_IN & bus.ExeRegWrite_IN & (bus.ExeDest_IN != REG_W'(ZERO_REG));
    stall = exe_wr & bus.ExeIsLoad_IN & ((bus.IdRs_IN == bus.ExeDest_IN) |
            (bus.IdUsesRt_IN & (bus.IdRt_IN == bus.ExeDest_IN)));
    s1_d = '{valid: exe_wr & ~bus.Flush_IN, dest: bus.ExeDest_IN,
             data: bus.ALUResult_IN, is_load: bus.ExeIsLoad_IN};
    s2_d = s1_q;
    s2_d.data = s1_q.is_load ? bus.MemData_IN : s1_q.data;
    s2_d.is_load = 1'b0;
    m1a = s1_q.valid & (s1_q.dest == bus.ExeRs_IN);
    m2a = s2_q.valid & (s2_q.dest == bus.ExeRs_IN);
    m1b = bus.ExeUsesRt_IN & s1_q.valid & (s1_q.dest == bus.ExeRt_IN);
    m2b = bus.ExeUsesRt_IN & s2_q.valid & (s2_q.dest == bus.ExeRt_IN);
    fwd = m1a | m1b;
    opa = m1a ? s1_q.data : m2a ? s2_q.data : bus.ExeOperandA_IN;
    opb = m1b ? s1_q.data : m2b ? s2_q.data : bus.ExeOperandB_IN;
    // S2 never holds an unresolved load, so only the S1 term can fire
    hazard_d = hazard_q | (s1_q.is_load & fwd) | (s2_q.is_load & (m2a | m2b));
    cnt_d = (stall && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  fwd_stage_reg #(.entry_t(entry_t)) u_s1 (.CLOCK(CLOCK), .RESET(RESET), .entry_d(s1_d), .entry_o(s1_q));
  fwd_stage_reg #(.entry_t(entry_t)) u_s2 (.CLOCK(CLOCK), .RESET(RESET), .entry_d(s2_d), .entry_o(s2_q));
  always_ff @(posedge CLOCK) begin
    hazard_q <= RESET ? hazard_d : 1'b0;
    cnt_q <= RESET ? cnt_d : '0;
  end
  assign bus.forward_OUT = fwd;
  assign bus.Fmem_forward_OUT = ~fwd & (m2a | m2b);
  assign bus.FOperandA_OUT = opa;
  assign bus.FOperandB_OUT = opb;
  assign bus.S_operandA_OUT = opa;
  assign bus.S_operandB_OUT = opb;
  assign bus.Stall_OUT = stall;
  assign bus.HazardErr_OUT = hazard_q;
  assign bus.StallCount_OUT = cnt_q;
endmodule

// File: doc/forward_ctrl.md
FORWARD_CTRL -- requirements
Module: forward_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand/result width.
REQ-002 SHALL have parameter REG_W, default 5: register index width.
REQ-003 SHALL have parameter CNT_W, default 16: stall counter width.
REQ-004 CLOCK  in  1  sole clock; all state updates on rising edge.
REQ-005 RESET  in  1  synchronous, active-low reset, sampled on rising CLOCK.
REQ-006 ExeValid_IN  in  1  instruction in EXE this cycle is real (0 = bubble).
REQ-007 ExeRegWrite_IN  in  1  EXE instruction writes a GPR.
REQ-008 ExeIsLoad_IN  in  1  EXE instruction is a load.
REQ-009 ExeDest_IN  in  REG_W  EXE destination register.
REQ-010 ExeRs_IN / ExeRt_IN  in  REG_W each  EXE source registers.
REQ-011 ExeOperandA_IN / ExeOperandB_IN  in  DATA_W each  operands read from the ID/EXE register.
REQ-012 ExeUsesRt_IN  in  1  OperandB comes from rt (0 = immediate; no B forwarding).
REQ-013 ALUResult_IN  in  DATA_W  EXE ALU result of the current instruction.
REQ-014 MemData_IN  in  DATA_W  load data leaving MEM this cycle.
REQ-015 IdRs_IN / IdRt_IN  in  REG_W each; IdUsesRt_IN  in  1: sources of the instruction in ID.
REQ-016 Flush_IN  in  1  current EXE instruction is squashed; it is not captured.
REQ-017 forward_OUT  out  1  EXE selects FOperandA/B_OUT.
REQ-018 Fmem_forward_OUT  out  1  EXE selects S_operandA/B_OUT (meaningful only when forward_OUT=0).
REQ-019 FOperandA_OUT / FOperandB_OUT  out  DATA_W each  resolved operands.
REQ-020 S_operandA_OUT / S_operandB_OUT  out  DATA_W each  resolved operands (identical to F*).
REQ-021 Stall_OUT  out  1  hold PC and IF/ID; insert a bubble into ID/EXE.
REQ-022 HazardErr_OUT  out  1  sticky protocol-violation flag.
REQ-023 StallCount_OUT  out  CNT_W  number of stall cycles.

Function
REQ-024 SHALL hold two shadow entries {valid, dest, data, is_load}: S1 (EXE/MEM) and S2 (MEM/WB).
REQ-025 Each clock: S1.valid <= ExeValid & ExeRegWrite & ~Flush & (ExeDest != 0); S1.dest <= ExeDest_IN; S1.data <= ALUResult_IN; S1.is_load <= ExeIsLoad_IN.
REQ-026 Each clock: S2 <= S1, with S2.data <= (S1.is_load ? MemData_IN : S1.data).
REQ-027 Per operand X in {A,B}: match1X = S1.valid & S1.dest==srcX; match2X = S2.valid & S2.dest==srcX; srcA = ExeRs_IN; srcB = ExeRt_IN, with B matches forced 0 when ExeUsesRt_IN=0.
REQ-028 Resolved operand X priority: S1.data if match1X, else S2.data if match2X, else ExeOperandX_IN (youngest writer wins).
REQ-029 forward_OUT = match1A | match1B; Fmem_forward_OUT = ~forward_OUT & (match2A | match2B); both combinational, zero latency.
REQ-030 Register 0 is never forwarded (guaranteed by REQ-025).
REQ-031 Stall_OUT = ExeValid & ExeRegWrite & ExeIsLoad & ExeDest!=0 & (IdRs==ExeDest | (IdUsesRt & IdRt==ExeDest)); combinational; one cycle per load-use pair.
REQ-032 Forwarding from a load in S1 is illegal (stall prevents it); if a match1X occurs with S1.is_load=1, HazardErr_OUT SHALL set on the next edge and hold until reset; the operand is still S1.data.
REQ-033 StallCount_OUT SHALL increment on each edge where Stall_OUT=1, saturating at all-ones.
REQ-034 Flush_IN and Stall_OUT asserted together: Flush wins for capture; Stall_OUT is still reported.

Reset
REQ-035 RESET=0 at a rising edge SHALL clear S1.valid, S2.valid, HazardErr_OUT and StallCount_OUT; data/dest fields are don't-care.
REQ-036 While state is reset, forward_OUT=0 and Fmem_forward_OUT=0, and the resolved operands equal ExeOperandA/B_IN.
REQ-037 Reset mid-stream SHALL drop all in-flight entries; no forwarding occurs on the first cycle after reset.

Structure
REQ-038 The shared package SHALL hold DATA_W, REG_W, the zero-register constant, and the shadow-entry struct typedef.
REQ-039 One sub-module, fwd_stage_reg (one shadow entry with sync active-low clear), SHALL be instantiated twice.

Verification
REQ-040 Back-to-back: add $3=5+7 then sub $4,$3,$1 -> next cycle forward_OUT=1, FOperandA_OUT=12.
REQ-041 Distance 2: writer $3=0xAA, one independent instruction, then reader of $3 -> forward_OUT=0, Fmem_forward_OUT=1, S_operandA_OUT=0xAA.
REQ-042 Both stages write $5 (S1=0x2, S2=0x1); reader of $5 -> FOperandA_OUT=0x2.
REQ-043 lw $6 in EXE, ID reads $6 -> Stall_OUT=1 for exactly one cycle, StallCount_OUT=1; two cycles later Fmem_forward_OUT=1 with operand = MemData_IN (e.g. 0xDEADBEEF).
REQ-044 Writer to $0 (result 0x55), then reader of $0 -> no forward; operand = ExeOperandA_IN (0). Flushed writer to $7 -> no forward of $7.
REQ-045 Pipeline loaded with a $3 writer, RESET=0 for one edge, then reader of $3 -> forward_OUT=0, HazardErr_OUT=0, StallCount_OUT=0.
